// File: rtl/gf180_ram_128x8_ctrl.sv
// Initiator-side controller for the 128x8 GF180 SRAM macro: post-reset zero-fill,
// valid/ready request port, single-outstanding valid/ready read-response port.
module gf180_ram_128x8_ctrl #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 8,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [DATA_W-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((2 ** ADDR_W) - 1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RSP     = 2'd3
    } state_e;

    localparam state_e ST_RESET = INIT_CLEAR ? ST_INIT : ST_IDLE;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              fire;

    // Request acceptance: only in IDLE, never while reset is held.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !RST;
        fire      = req_valid && req_ready;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_INIT: begin
                // Counter stops at the last address; no second pass.
                if (cnt_q == CNT_MAX) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (fire && !req_we) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Macro Q is valid this cycle; capture it for the response.
                rsp_rdata_d = sram_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            init_done_q <= !INIT_CLEAR;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Macro pins follow the fill counter or the firing request in the same cycle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (!RST) begin
            if (state_q == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt_q[ADDR_W-1:0];
            end else if (fire) begin
                sram_cen = 1'b0;
                sram_a   = req_addr;
                sram_d   = req_wdata;
                if (req_we) begin
                    sram_gwen = 1'b0;
                    sram_wen  = ~req_wmask;
                end
            end
        end
    end

    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gf180_ram_128x8_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus a word-array reference model.
module tb_gf180_ram_128x8_ctrl;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 128;

    logic              CLK = 1'b0;
    logic              RST;
    logic              init_done;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sram_cen;
    logic              sram_gwen;
    logic [DATA_W-1:0] sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    gf180_ram_128x8_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CLEAR(1'b1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Macro model: synchronous, per-bit active-low write enable, Q updated on read.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Checks n fill cycles starting at address 0; entered just after reset release.
    task automatic check_fill(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("fill_a", 32'(sram_a), 32'(i));
            chk("fill_cen_gwen", {sram_cen, sram_gwen}, 2'b00);
            chk("fill_wen_d", {sram_wen, sram_d}, 16'h0000);
            chk("fill_rdy_done", {req_ready, init_done}, 2'b00);
            tick();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        #1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] nm;
        nm = ~m;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        #1;
        chk("wr_cen_gwen", {sram_cen, sram_gwen}, 2'b00);
        chk("wr_wen", 32'(sram_wen), 32'(nm));
        chk("wr_a", 32'(sram_a), 32'(a));
        chk("wr_d", 32'(sram_d), 32'(d));
        tick();
        req_valid = 1'b0;
        ref_mem[a] = (ref_mem[a] & nm) | (d & m);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int hold);
        logic [DATA_W-1:0] exp;
        wait_ready();
        exp       = ref_mem[a];
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = DATA_W'($urandom);
        #1;
        chk("rd_pins", {sram_cen, sram_gwen, sram_wen, sram_a}, {2'b01, 8'hFF, a});
        tick();
        // Stray requests and early rsp_ready while waiting must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = ADDR_W'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        chk("rdw_valid_rdy", {rsp_valid, req_ready}, 2'b00);
        chk("rdw_cen", 32'(sram_cen), 32'd1);
        tick();
        for (int i = 0; i <= hold; i++) begin
            rsp_ready = (i == hold);
            #1;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
            chk("rsp_rdy_cen", {req_ready, sram_cen}, 2'b01);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = DATA_W'($urandom);
        sram_q    = '0;
        RST       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'h33;
        req_wdata = 8'h5A;
        req_wmask = 8'hFF;
        rsp_ready = 1'b0;
        repeat (3) tick();

        // Reset values, with a request presented that must not reach the pins.
        chk("rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {2'b11, 8'hFF, 7'h00, 8'h00});
        chk("rst_flops", {init_done, rsp_valid, rsp_rdata, req_ready}, 11'h000);
        req_valid = 1'b0;

        // Partial fill, then asynchronous reset in the middle of it.
        RST = 1'b0;
        check_fill(60);
        #2;
        RST = 1'b1;
        #1;
        chk("midfill_rst_pins", {sram_cen, sram_gwen, sram_a}, {2'b11, 7'h00});
        chk("midfill_rst_done", 32'(init_done), 32'd0);
        tick();
        tick();

        // Full fill after release: 128 cycles, then ready.
        RST = 1'b0;
        check_fill(128);
        #1;
        chk("init_done", {init_done, req_ready}, 2'b11);
        clear_ref();

        do_read(7'h45, 0);
        do_write(7'h10, 8'hA5, 8'hFF);
        do_read(7'h10, 0);
        do_write(7'h10, 8'h0F, 8'h0F);
        do_read(7'h10, 5);
        do_write(7'h10, 8'h55, 8'h00);
        do_read(7'h10, 1);

        // Back-to-back writes with req_valid held high.
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = ADDR_W'(i);
            req_wdata = DATA_W'($urandom);
            req_wmask = 8'hFF;
            #1;
            chk("b2b_cen_a", {sram_cen, sram_a}, {1'b0, 7'(i)});
            tick();
            ref_mem[i] = req_wdata;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) do_read(ADDR_W'(i), 0);

        // Random mix of masked writes and reads on a small address window.
        repeat (300) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, DATA_W'($urandom), DATA_W'($urandom));
            end else begin
                do_read(a, int'($urandom_range(0, 3)));
            end
        end

        // Reset while a response is pending discards it.
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'h10;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_rsp_valid", {rsp_valid, sram_cen}, 2'b01);
        tick();
        RST = 1'b0;
        clear_ref();
        begin
            int n = 0;
            while (!init_done && n < 200) begin
                tick();
                n++;
            end
            chk("refill_timeout", 32'(init_done), 32'd1);
            chk("refill_cycles", 32'(n), 32'd128);
        end
        do_read(7'h10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
